apb_slave: RTL and testbench

APB_SLAVE -- requirements
Module: apb_slave

---
 rtl/apb_slave.sv | 125 ++++++++++++
 tb/tb_apb_slave.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave.sv
// rtl/apb_slave.sv - APB register-file slave with parameterised wait states
module apb_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata
);
    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pready_q, pready_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  mem_we;
    logic                  setup;
    logic [IDX_W-1:0]      paddr_idx;
    logic                  unused_paddr;

    assign paddr_idx    = paddr[IDX_W+1:2];
    assign setup        = psel && !penable;
    assign unused_paddr = ^paddr;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        pready_d   = 1'b0;
        prdata_d   = prdata_q;
        mem_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    state_d    = ST_ACCESS;
                    wait_cnt_d = WAIT_INIT;
                    idx_d      = paddr_idx;
                    write_d    = pwrite;
                    wdata_d    = pwdata;
                    // Zero wait states: complete in the first access cycle.
                    if (WAIT_INIT == 4'd0) begin
                        pready_d = 1'b1;
                        if (!pwrite) begin
                            prdata_d = mem_q[paddr_idx];
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 4'd0;
                end else if (pready_q) begin
                    state_d = ST_IDLE;
                    mem_we  = write_q && penable;
                end else if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                    // Last wait cycle: raise pready and present read data together.
                    if (wait_cnt_q == 4'd1) begin
                        pready_d = 1'b1;
                        if (!write_q) begin
                            prdata_d = mem_q[idx_q];
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            pready_q   <= 1'b0;
            prdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            pready_q   <= pready_d;
            prdata_q   <= prdata_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign pready = pready_q;
    assign prdata = prdata_q;

endmodule

// File: tb/tb_apb_slave.sv
// tb/tb_apb_slave.sv - randomized self-checking bench for apb_slave (0 and 2 wait states)
module tb_apb_slave;
    localparam int DEPTH = 256;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] paddr = '0;
    logic        psel0 = 1'b0;
    logic        psel2 = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        pready0, pready2;
    logic [31:0] prdata0, prdata2;

    int checks = 0;
    int passes = 0;

    logic [31:0] ref0 [DEPTH];
    logic [31:0] ref2 [DEPTH];
    logic [31:0] last_rd0, last_rd2;

    apb_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .pclk(pclk), .rst_n(rst_n), .paddr(paddr), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready0), .prdata(prdata0)
    );

    apb_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
        .pclk(pclk), .rst_n(rst_n), .paddr(paddr), .psel(psel2), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready2), .prdata(prdata2)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            ref0[i] = '0;
            ref2[i] = '0;
        end
        last_rd0 = '0;
        last_rd2 = '0;
    endtask

    task automatic do_reset();
        psel0 = 1'b0;
        psel2 = 1'b0;
        penable = 1'b0;
        rst_n = 1'b0;
        @(posedge pclk); #1;
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic idle();
        psel0 = 1'b0;
        psel2 = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    // Bus driver: starts at posedge+1, ends at posedge+1 after the completing edge with psel still high.
    task automatic xfer(input bit use2, input logic [31:0] addr, input bit wr, input logic [31:0] data,
                        output logic [31:0] rd, output int cyc, output logic post_rdy);
        logic rdy;
        paddr = addr;
        pwrite = wr;
        pwdata = data;
        penable = 1'b0;
        psel0 = !use2;
        psel2 = use2;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 1;
        @(negedge pclk);
        rdy = use2 ? pready2 : pready0;
        while (!rdy && cyc < 40) begin
            @(posedge pclk); #1;
            cyc++;
            @(negedge pclk);
            rdy = use2 ? pready2 : pready0;
        end
        if (!rdy) cyc = 99;
        rd = use2 ? prdata2 : prdata0;
        @(posedge pclk); #1;
        post_rdy = use2 ? pready2 : pready0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int cyc;
        logic pr;
        do_reset();
        checks++; if (pready0 !== 1'b0) $display("FAIL reset_pready0: got %b expected 0", pready0); else passes++;
        checks++; if (prdata0 !== 32'h0) $display("FAIL reset_prdata0: got %h expected 0", prdata0); else passes++;
        checks++; if (pready2 !== 1'b0) $display("FAIL reset_pready2: got %b expected 0", pready2); else passes++;
        checks++; if (prdata2 !== 32'h0) $display("FAIL reset_prdata2: got %h expected 0", prdata2); else passes++;
        xfer(0, 32'h04, 0, 32'h0, rd, cyc, pr);
        checks++; if (cyc !== 1) $display("FAIL reset_read_cycles: got %0d expected 1", cyc); else passes++;
        checks++; if (rd !== 32'h0) $display("FAIL reset_read_data: got %h expected 0", rd); else passes++;
        checks++; if (pr !== 1'b0) $display("FAIL reset_read_pready_after: got %b expected 0", pr); else passes++;
        idle();
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int cyc;
        logic pr;
        xfer(0, 32'h10, 1, 32'hDEADBEEF, rd, cyc, pr);
        ref0[widx(32'h10)] = 32'hDEADBEEF;
        checks++; if (cyc !== 1) $display("FAIL wr10_cycles: got %0d expected 1", cyc); else passes++;
        idle();
        xfer(0, 32'h10, 0, 32'h0, rd, cyc, pr);
        checks++; if (cyc !== 1) $display("FAIL rd10_cycles: got %0d expected 1", cyc); else passes++;
        checks++; if (rd !== ref0[widx(32'h10)]) $display("FAIL rd10_data: got %h expected %h", rd, ref0[widx(32'h10)]); else passes++;
        last_rd0 = rd;
        idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        int cyc;
        logic pr;
        xfer(1, 32'h20, 1, 32'h12345678, rd, cyc, pr);
        ref2[widx(32'h20)] = 32'h12345678;
        checks++; if (cyc !== 3) $display("FAIL ws_write_cycles: got %0d expected 3", cyc); else passes++;
        checks++; if (pr !== 1'b0) $display("FAIL ws_pready_one_cycle: got %b expected 0", pr); else passes++;
        idle();
        xfer(1, 32'h20, 0, 32'h0, rd, cyc, pr);
        checks++; if (cyc !== 3) $display("FAIL ws_read_cycles: got %0d expected 3", cyc); else passes++;
        checks++; if (rd !== 32'h12345678) $display("FAIL ws_read_data: got %h expected 12345678", rd); else passes++;
        last_rd2 = rd;
        idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int cyc;
        logic pr;
        xfer(0, 32'h00, 1, 32'hA5A5A5A5, rd, cyc, pr);
        ref0[0] = 32'hA5A5A5A5;
        idle();
        paddr = 32'h00; pwrite = 1'b1; pwdata = 32'h0; penable = 1'b0; psel0 = 1'b1;
        @(posedge pclk); #1;
        psel0 = 1'b0; penable = 1'b1;
        @(posedge pclk); #1;
        checks++; if (pready0 !== 1'b0) $display("FAIL abort0_pready: got %b expected 0", pready0); else passes++;
        idle();
        xfer(0, 32'h00, 0, 32'h0, rd, cyc, pr);
        checks++; if (rd !== ref0[0]) $display("FAIL abort0_readback: got %h expected %h", rd, ref0[0]); else passes++;
        last_rd0 = rd;
        idle();
        xfer(1, 32'h00, 1, 32'hA5A5A5A5, rd, cyc, pr);
        ref2[0] = 32'hA5A5A5A5;
        idle();
        paddr = 32'h00; pwrite = 1'b1; pwdata = 32'h0; penable = 1'b0; psel2 = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel2 = 1'b0;
        @(posedge pclk); #1;
        checks++; if (pready2 !== 1'b0) $display("FAIL abort2_pready: got %b expected 0", pready2); else passes++;
        idle();
        xfer(1, 32'h00, 0, 32'h0, rd, cyc, pr);
        checks++; if (rd !== ref2[0]) $display("FAIL abort2_readback: got %h expected %h", rd, ref2[0]); else passes++;
        last_rd2 = rd;
        idle();
    endtask

    task automatic test_penable_only();
        logic [31:0] rd;
        int cyc;
        logic pr;
        int seen;
        seen = 0;
        paddr = 32'h44; pwrite = 1'b1; pwdata = 32'hCAFEF00D; psel0 = 1'b1; penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            if (pready0 !== 1'b0) seen++;
            @(posedge pclk); #1;
        end
        checks++; if (seen !== 0) $display("FAIL penable_only_pready: got %0d high cycles expected 0", seen); else passes++;
        idle();
        xfer(0, 32'h44, 0, 32'h0, rd, cyc, pr);
        checks++; if (rd !== ref0[widx(32'h44)]) $display("FAIL penable_only_mem: got %h expected %h", rd, ref0[widx(32'h44)]); else passes++;
        last_rd0 = rd;
        idle();
    endtask

    task automatic test_alias();
        logic [31:0] rd;
        int cyc;
        logic pr;
        xfer(0, 32'h08, 1, 32'h55, rd, cyc, pr);
        ref0[widx(32'h08)] = 32'h55;
        idle();
        xfer(0, 32'h08 + DEPTH * 4, 0, 32'h0, rd, cyc, pr);
        checks++; if (rd !== 32'h00000055) $display("FAIL alias_read: got %h expected 00000055", rd); else passes++;
        last_rd0 = rd;
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int cyc;
        logic pr;
        xfer(0, 32'h3C, 1, 32'h0BADCAFE, rd, cyc, pr);
        ref0[widx(32'h3C)] = 32'h0BADCAFE;
        xfer(0, 32'h3C, 0, 32'h0, rd, cyc, pr);
        checks++; if (cyc !== 1) $display("FAIL b2b_read_cycles: got %0d expected 1", cyc); else passes++;
        checks++; if (rd !== 32'h0BADCAFE) $display("FAIL b2b_raw0: got %h expected 0badcafe", rd); else passes++;
        last_rd0 = rd;
        xfer(1, 32'h3C, 1, 32'h600DF00D, rd, cyc, pr);
        ref2[widx(32'h3C)] = 32'h600DF00D;
        xfer(1, 32'h3C, 0, 32'h0, rd, cyc, pr);
        checks++; if (rd !== 32'h600DF00D) $display("FAIL b2b_raw2: got %h expected 600df00d", rd); else passes++;
        last_rd2 = rd;
        idle();
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, data, exp;
        int cyc, exp_cyc;
        logic pr;
        bit use2, wr;
        for (int n = 0; n < 80; n++) begin
            use2 = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            addr = $urandom & 32'hFFFF_F03F;
            data = $urandom;
            exp_cyc = use2 ? 3 : 1;
            xfer(use2, addr, wr, data, rd, cyc, pr);
            checks++; if (cyc !== exp_cyc) $display("FAIL rand_cycles[%0d]: got %0d expected %0d", n, cyc, exp_cyc); else passes++;
            checks++; if (pr !== 1'b0) $display("FAIL rand_pready_pulse[%0d]: got %b expected 0", n, pr); else passes++;
            if (wr) begin
                exp = use2 ? last_rd2 : last_rd0;
                checks++; if (rd !== exp) $display("FAIL rand_prdata_hold[%0d]: got %h expected %h", n, rd, exp); else passes++;
                if (use2) ref2[widx(addr)] = data; else ref0[widx(addr)] = data;
            end else begin
                exp = use2 ? ref2[widx(addr)] : ref0[widx(addr)];
                checks++; if (rd !== exp) $display("FAIL rand_read[%0d] addr %h: got %h expected %h", n, addr, rd, exp); else passes++;
                if (use2) last_rd2 = rd; else last_rd0 = rd;
            end
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
    endtask

    task automatic test_reset_clears();
        logic [31:0] rd;
        int cyc;
        logic pr;
        xfer(0, 32'h0C, 1, 32'h1, rd, cyc, pr);
        idle();
        do_reset();
        xfer(0, 32'h0C, 0, 32'h0, rd, cyc, pr);
        checks++; if (rd !== 32'h0) $display("FAIL reset_clears_mem: got %h expected 0", rd); else passes++;
        idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int cyc;
        logic pr;
        xfer(1, 32'h30, 1, 32'h77, rd, cyc, pr);
        xfer(1, 32'h30, 0, 32'h0, rd, cyc, pr);
        checks++; if (rd !== 32'h77) $display("FAIL mid_pre_read: got %h expected 77", rd); else passes++;
        idle();
        paddr = 32'h30; pwrite = 1'b1; pwdata = 32'h99; penable = 1'b0; psel2 = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b1;
        rst_n = 1'b0;
        @(posedge pclk); #1;
        checks++; if (pready2 !== 1'b0) $display("FAIL mid_reset_pready: got %b expected 0", pready2); else passes++;
        checks++; if (prdata2 !== 32'h0) $display("FAIL mid_reset_prdata: got %h expected 0", prdata2); else passes++;
        rst_n = 1'b1;
        clear_model();
        idle();
        xfer(1, 32'h30, 0, 32'h0, rd, cyc, pr);
        checks++; if (rd !== 32'h0) $display("FAIL mid_reset_mem: got %h expected 0", rd); else passes++;
        idle();
    endtask

    initial begin
        clear_model();
        test_reset();
        test_write_read();
        test_wait_states();
        test_abort();
        test_penable_only();
        test_alias();
        test_back_to_back();
        test_random();
        test_reset_clears();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
